// File: rtl/bus_split_if.sv
// Handshake bundle for bus_split: packed input word on the upstream side,
// unpacked A/B fields plus delivered-word count on the downstream side.
interface bus_split_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       Din;
    logic             X;
    logic             Y;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       A;
    logic [2:0]       B;
    logic [CNT_W-1:0] count;

    modport slave (
        input  in_valid, Din, X, Y, out_ready,
        output in_ready, out_valid, A, B, count
    );

    modport master (
        output in_valid, Din, X, Y, out_ready,
        input  in_ready, out_valid, A, B, count
    );
endinterface

// File: rtl/bus_split.sv
// Two-entry FIFO that repacks {Din, X, Y} into A/B fields, with an
// occupancy FSM and a wrapping delivered-word counter.
//
// state | meaning
// EMPTY | no word stored, out_valid low
// ONE   | one word stored at rd_ptr
// TWO   | both entries full, in_ready low
module bus_split #(
    parameter int CNT_W = 8
) (
    input  logic      clk,
    input  logic      reset,
    bus_split_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;
    logic [7:0]       head;

    // Ready/valid decode from the state register only, so out_ready never
    // reaches in_ready combinationally.
    assign bus.in_ready  = (state != TWO);
    assign bus.out_valid = (state != EMPTY);

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    assign head      = bus.out_valid ? mem[rd_ptr] : 8'h00;
    assign bus.A     = head[4:0];
    assign bus.B     = head[7:5];
    assign bus.count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= '0;
            mem[0]  <= 8'h00;
            mem[1]  <= 8'h00;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.Din[5:3], bus.Y, bus.X, bus.Din[2:0]};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                count_q <= count_q + 1'b1;
            end
            unique case (state)
                EMPTY: if (push) state <= ONE;
                ONE: begin
                    if (push && !pop)      state <= TWO;
                    else if (pop && !push) state <= EMPTY;
                end
                TWO:   if (pop) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: doc/bus_split.md
BUS_SPLIT -- requirements
Module: bus_split

Interface
REQ-001 Parameter CNT_W, default 8; width of the delivered-word counter.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 in_valid  input  1  upstream asserts that Din, X and Y hold a valid packed word.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 Din  input  6  packed word; Din[5:3] is field B, Din[2:0] is A[2:0].
REQ-007 X  input  1  carries A[3]; sampled with Din.
REQ-008 Y  input  1  carries A[4]; sampled with Din.
REQ-009 out_valid  output  1  A and B hold a valid unpacked word.
REQ-010 out_ready  input  1  downstream accepts the word this cycle.
REQ-011 A  output  5  unpacked field: {Y, X, Din[2:0]}.
REQ-012 B  output  3  unpacked field: Din[5:3].
REQ-013 count  output  CNT_W  number of words delivered downstream.

Function
REQ-014 A push occurs on any edge where in_valid and in_ready are both high; a pop occurs on any edge where out_valid and out_ready are both high.
REQ-015 The block shall store words in a 2-entry FIFO, each entry 8 bits: {Din[5:3], Y, X, Din[2:0]}.
REQ-016 The occupancy FSM shall have states EMPTY, ONE and TWO.
REQ-017 The FSM shall move EMPTY->ONE on a push; ONE->TWO on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push and pop; TWO->ONE on pop; otherwise it holds its state.
REQ-018 in_ready shall be high exactly when the state is not TWO, decoded from state only, with no combinational path from out_ready.
REQ-019 In TWO with out_ready high, no push shall occur that cycle, even if in_valid is high.
REQ-020 out_valid shall be high exactly when the state is not EMPTY.
REQ-021 A and B shall be driven from the head entry; when out_valid is low they shall read 0.
REQ-022 Latency: a word pushed at edge N shall be presented on A/B with out_valid high after edge N (one cycle) when the FIFO was EMPTY.
REQ-023 In ONE with simultaneous push and pop, the new word shall become the head after the edge, and A/B shall change with no out_valid gap.
REQ-024 Order shall be strictly FIFO; no word shall be dropped or duplicated.
REQ-025 Write and read pointers shall be 1 bit each and wrap modulo 2.
REQ-026 count shall increment by 1 per pop and wrap from 2^CNT_W-1 to 0.
REQ-027 A and B shall be held stable while out_valid is high and out_ready is low.
REQ-028 in_valid asserted while in_ready is low shall cause no state change.

Reset
REQ-029 While reset is high at an edge, the block shall set state to EMPTY, both pointers to 0, count to 0 and both FIFO entries to 0.
REQ-030 Outputs during and after reset shall be: out_valid=0, A=0, B=0, count=0, in_ready=1.
REQ-031 Reset shall take priority over a simultaneous push or pop; in-flight words are discarded.

Verification
REQ-032 Single word: Din=6'b101_011, X=1, Y=0, out_ready=1 -> next cycle out_valid=1, A=5'b01011, B=3'b101; count=1 after the pop.
REQ-033 Back-pressure: out_ready=0, push 0x15 then 0x2A -> after the second push state is TWO and in_ready=0; a third word offered is ignored; raising out_ready yields 0x15 then 0x2A in order.
REQ-034 Streaming: in_valid=1 and out_ready=1 for 10 cycles with an incrementing Din -> out_valid continuous after the first cycle, words in order, count=10.
REQ-035 TWO with pop: full FIFO, out_ready=1 and in_valid=1 -> one pop, no push; state becomes ONE and in_ready rises the next cycle.
REQ-036 Reset mid-operation: FIFO in TWO, assert reset for one cycle with in_valid=1 -> out_valid=0, count=0, in_ready=1; stored words are never output.
REQ-037 Counter wrap with CNT_W=4: deliver 17 words -> count reads 15 then 0 then 1.
